// File: rtl/gtype.sv
// Shared XGMII types and control characters for the lane gearbox.
package gtype;

    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERR   = 8'hFE;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;

    typedef struct packed {
        logic       ctrl;
        logic [7:0] data;
    } xgmii_lane_t;

    localparam xgmii_lane_t LANE_ERR = '{ctrl: 1'b1, data: XGMII_ERR};

    typedef enum logic {IN_PASS, IN_DISCARD} in_state_e;
    typedef enum logic [1:0] {OUT_IDLE, OUT_FRAME, OUT_FLUSH} out_state_e;

    function automatic logic is_char(input xgmii_lane_t lane, input logic [7:0] code);
        return lane.ctrl && (lane.data == code);
    endfunction

endpackage

// File: rtl/xgmii_lane_fifo.sv
// Single-clock circular lane buffer: writes WR_LANES lanes at once, pops a
// variable lane count, exposes the RD_LANES oldest lanes and a level counter.
module xgmii_lane_fifo
    import gtype::*;
#(
    parameter int WR_LANES = 4,
    parameter int RD_LANES = 8,
    parameter int DEPTH    = 32,
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = AW + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  xgmii_lane_t [WR_LANES-1:0]   wr_lanes_i,
    input  logic [LW-1:0]                pop_n_i,
    output xgmii_lane_t [RD_LANES-1:0]   rd_lanes_o,
    output logic [LW-1:0]                level_o
);

    xgmii_lane_t    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [LW-1:0]  level_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            for (int i = 0; i < WR_LANES; i++) begin
                mem_q[wr_ptr_q + AW'(i)] <= wr_lanes_i[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(WR_LANES);
            end
            rd_ptr_q <= rd_ptr_q + pop_n_i[AW-1:0];
            level_q  <= level_q + (push_i ? LW'(WR_LANES) : '0) - pop_n_i;
        end
    end

    always_comb begin
        for (int i = 0; i < RD_LANES; i++) begin
            rd_lanes_o[i] = mem_q[rd_ptr_q + AW'(i)];
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/xgmii_lane_gearbox.sv
// XGMII width converter / elastic buffer with overflow frame discard and underrun flush.
// Optional counters enabled by defining XGMII_LANE_GEARBOX_STATS_EN.
module xgmii_lane_gearbox
    import gtype::*;
#(
    parameter int IN_LANES    = 4,
    parameter int OUT_LANES   = 8,
    parameter int DEPTH_LANES = 32,
    localparam int LW         = $clog2(DEPTH_LANES) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_ena,
    input  logic [IN_LANES-1:0]    in_ctrl,
    input  logic [8*IN_LANES-1:0]  in_data,
    input  logic                   out_rdy,
    output logic                   out_ena,
    output logic [OUT_LANES-1:0]   out_ctrl,
    output logic [8*OUT_LANES-1:0] out_data,
    output logic [LW-1:0]          level,
    output logic                   overflow,
    output logic                   underrun,
    input  logic                   clr_flags
`ifdef XGMII_LANE_GEARBOX_STATS_EN
    ,
    output logic [31:0]            stat_frames,
    output logic [15:0]            stat_drops,
    output logic [15:0]            stat_errs
`endif
);

    localparam logic [LW-1:0] IN_W    = LW'(IN_LANES);
    localparam logic [LW-1:0] OUT_W   = LW'(OUT_LANES);
    localparam logic [LW-1:0] DEPTH_W = LW'(DEPTH_LANES);

    xgmii_lane_t [IN_LANES-1:0]  in_lanes;
    xgmii_lane_t [IN_LANES-1:0]  wr_lanes;
    xgmii_lane_t [OUT_LANES-1:0] rd_lanes;
    logic                        push;
    logic [LW-1:0]               pop_n;
    logic [LW-1:0]               level_w;
    logic [LW-1:0]               free;

    in_state_e  in_state_q, in_state_d;
    out_state_e out_state_q, out_state_d;
    logic       e_pend_q, e_pend_d;
    logic       need_t_q, need_t_d;
    logic       open_q, open_d;
    logic       word_open, word_has_t;
    logic       ovf_set, unf_set;
    logic       overflow_q, underrun_q;
    logic       out_ena_q, out_ena_d;
    logic [OUT_LANES-1:0]   out_ctrl_q, out_ctrl_d;
    logic [8*OUT_LANES-1:0] out_data_q, out_data_d;
    out_state_e scan_st;
    logic       flush_hit;
    logic [LW-1:0] flush_cnt;
`ifdef XGMII_LANE_GEARBOX_STATS_EN
    logic [LW-1:0] t_cnt;
`endif

    xgmii_lane_fifo #(
        .WR_LANES (IN_LANES),
        .RD_LANES (OUT_LANES),
        .DEPTH    (DEPTH_LANES)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .wr_lanes_i (wr_lanes),
        .pop_n_i    (pop_n),
        .rd_lanes_o (rd_lanes),
        .level_o    (level_w)
    );

    assign free = DEPTH_W - level_w;

    always_comb begin
        for (int i = 0; i < IN_LANES; i++) begin
            in_lanes[i].ctrl = in_ctrl[i];
            in_lanes[i].data = in_data[8*i +: 8];
        end
    end

    // Frame-open tracking runs over the incoming word lane 0 first, last delimiter wins.
    always_comb begin
        in_state_d = in_state_q;
        e_pend_d   = e_pend_q;
        need_t_d   = need_t_q;
        open_d     = open_q;
        push       = 1'b0;
        wr_lanes   = in_lanes;
        ovf_set    = 1'b0;
        word_open  = open_q;
        word_has_t = 1'b0;
        for (int i = 0; i < IN_LANES; i++) begin
            if (is_char(in_lanes[i], XGMII_START)) begin
                word_open = 1'b1;
            end else if (is_char(in_lanes[i], XGMII_TERM)) begin
                word_open  = 1'b0;
                word_has_t = 1'b1;
            end
        end
        case (in_state_q)
            IN_PASS: begin
                if (in_ena) begin
                    if (free >= IN_W) begin
                        push   = 1'b1;
                        open_d = word_open;
                    end else begin
                        ovf_set    = 1'b1;
                        in_state_d = IN_DISCARD;
                        e_pend_d   = 1'b1;
                        need_t_d   = word_open;
                    end
                end
            end
            default: begin
                if (e_pend_q && (free >= IN_W)) begin
                    push     = 1'b1;
                    wr_lanes = {IN_LANES{LANE_ERR}};
                    e_pend_d = 1'b0;
                end
                if (in_ena && word_has_t) begin
                    need_t_d = 1'b0;
                end
                if (!e_pend_d && !need_t_d) begin
                    in_state_d = IN_PASS;
                    open_d     = 1'b0;
                end
            end
        endcase
    end

    // FLUSH drains regardless of out_rdy; only the visible window is scanned each cycle.
    always_comb begin
        out_state_d = out_state_q;
        pop_n       = '0;
        out_ena_d   = 1'b0;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
        unf_set     = 1'b0;
        scan_st     = out_state_q;
        flush_hit   = 1'b0;
        flush_cnt   = '0;
`ifdef XGMII_LANE_GEARBOX_STATS_EN
        t_cnt       = '0;
`endif
        if (out_state_q == OUT_FLUSH) begin
            for (int i = 0; i < OUT_LANES; i++) begin
                if (!flush_hit && (LW'(i) < level_w)) begin
                    flush_cnt = flush_cnt + 1'b1;
                    flush_hit = is_char(rd_lanes[i], XGMII_TERM);
                end
            end
            pop_n = flush_cnt;
            if (flush_hit) begin
                out_state_d = OUT_IDLE;
            end
        end else if (out_rdy) begin
            if (level_w >= OUT_W) begin
                pop_n     = OUT_W;
                out_ena_d = 1'b1;
                for (int i = 0; i < OUT_LANES; i++) begin
                    out_ctrl_d[i]         = rd_lanes[i].ctrl;
                    out_data_d[8*i +: 8]  = rd_lanes[i].data;
                    if (is_char(rd_lanes[i], XGMII_START)) begin
                        scan_st = OUT_FRAME;
                    end else if (is_char(rd_lanes[i], XGMII_TERM) && (scan_st == OUT_FRAME)) begin
                        scan_st = OUT_IDLE;
`ifdef XGMII_LANE_GEARBOX_STATS_EN
                        t_cnt = t_cnt + 1'b1;
`endif
                    end
                end
                out_state_d = scan_st;
            end else if (out_state_q == OUT_FRAME) begin
                out_ena_d   = 1'b1;
                out_ctrl_d  = '1;
                out_data_d  = {OUT_LANES{XGMII_ERR}};
                unf_set     = 1'b1;
                out_state_d = OUT_FLUSH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q  <= IN_PASS;
            out_state_q <= OUT_IDLE;
            e_pend_q    <= 1'b0;
            need_t_q    <= 1'b0;
            open_q      <= 1'b0;
            out_ena_q   <= 1'b0;
            out_ctrl_q  <= '0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            e_pend_q    <= e_pend_d;
            need_t_q    <= need_t_d;
            open_q      <= open_d;
            out_ena_q   <= out_ena_d;
            out_ctrl_q  <= out_ctrl_d;
            out_data_q  <= out_data_d;
            overflow_q  <= ovf_set | (overflow_q & ~clr_flags);
            underrun_q  <= unf_set | (underrun_q & ~clr_flags);
        end
    end

    assign out_ena  = out_ena_q;
    assign out_ctrl = out_ctrl_q;
    assign out_data = out_data_q;
    assign level    = level_w;
    assign overflow = overflow_q;
    assign underrun = underrun_q;

`ifdef XGMII_LANE_GEARBOX_STATS_EN
    logic [31:0] frames_q;
    logic [15:0] drops_q;
    logic [15:0] errs_q;
    logic [32:0] frames_sum;

    assign frames_sum = {1'b0, frames_q} + 33'(t_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_q <= '0;
            drops_q  <= '0;
            errs_q   <= '0;
        end else if (clr_flags) begin
            frames_q <= '0;
            drops_q  <= '0;
            errs_q   <= '0;
        end else begin
            frames_q <= frames_sum[32] ? '1 : frames_sum[31:0];
            if (ovf_set && (drops_q != '1)) begin
                drops_q <= drops_q + 1'b1;
            end
            if (unf_set && (errs_q != '1)) begin
                errs_q <= errs_q + 1'b1;
            end
        end
    end

    assign stat_frames = frames_q;
    assign stat_drops  = drops_q;
    assign stat_errs   = errs_q;
`endif

endmodule

// File: tb/tb_xgmii_lane_gearbox.sv
// Directed scoreboard bench for xgmii_lane_gearbox: 4->8 and 8->4 instances.
module tb_xgmii_lane_gearbox;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_in_ena, a_out_rdy, a_clr;
    logic [3:0]  a_in_ctrl;
    logic [31:0] a_in_data;
    logic        a_out_ena, a_ovf, a_unf;
    logic [7:0]  a_out_ctrl;
    logic [63:0] a_out_data;
    logic [5:0]  a_level;

    logic        b_in_ena, b_out_rdy, b_clr;
    logic [7:0]  b_in_ctrl;
    logic [63:0] b_in_data;
    logic        b_out_ena, b_ovf, b_unf;
    logic [3:0]  b_out_ctrl;
    logic [31:0] b_out_data;
    logic [5:0]  b_level;

`ifdef XGMII_LANE_GEARBOX_STATS_EN
    logic [31:0] a_sf, b_sf;
    logic [15:0] a_sd, a_se, b_sd, b_se;
`endif

    logic [71:0] qa[$];
    logic [71:0] qb[$];
    int compared   = 0;
    int mismatched = 0;

    localparam logic [3:0]  W0C = 4'h1, W1C = 4'h0, W2C = 4'hE, W3C = 4'hF, WXC = 4'h0;
    localparam logic [31:0] W0D = 32'h555555FB, W1D = 32'h332211D5,
                            W2D = 32'h0707FD44, W3D = 32'h07070707, WXD = 32'hDDCCBBAA;

    always #5 clk = ~clk;

    xgmii_lane_gearbox #(.IN_LANES(4), .OUT_LANES(8), .DEPTH_LANES(32)) dut_a (
        .clk(clk), .rst(rst), .in_ena(a_in_ena), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_rdy(a_out_rdy), .out_ena(a_out_ena), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .level(a_level), .overflow(a_ovf), .underrun(a_unf), .clr_flags(a_clr)
`ifdef XGMII_LANE_GEARBOX_STATS_EN
        , .stat_frames(a_sf), .stat_drops(a_sd), .stat_errs(a_se)
`endif
    );

    xgmii_lane_gearbox #(.IN_LANES(8), .OUT_LANES(4), .DEPTH_LANES(32)) dut_b (
        .clk(clk), .rst(rst), .in_ena(b_in_ena), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_rdy(b_out_rdy), .out_ena(b_out_ena), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .level(b_level), .overflow(b_ovf), .underrun(b_unf), .clr_flags(b_clr)
`ifdef XGMII_LANE_GEARBOX_STATS_EN
        , .stat_frames(b_sf), .stat_drops(b_sd), .stat_errs(b_se)
`endif
    );

    task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every cycle, any valid output word is matched against the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (a_out_ena === 1'b1) begin
            if (qa.size() == 0) begin
                compared++;
                mismatched++;
                $error("[TB] FAIL A unexpected word: observed %h expected none", {a_out_ctrl, a_out_data});
            end else begin
                checkOutput("A word", {a_out_ctrl, a_out_data}, qa.pop_front());
            end
        end
        if (b_out_ena === 1'b1) begin
            if (qb.size() == 0) begin
                compared++;
                mismatched++;
                $error("[TB] FAIL B unexpected word: observed %h expected none", {b_out_ctrl, b_out_data});
            end else begin
                checkOutput("B word", {36'b0, b_out_ctrl, b_out_data}, qb.pop_front());
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] c, input logic [31:0] d);
        a_in_ena  = 1'b1;
        a_in_ctrl = c;
        a_in_data = d;
        tick();
        a_in_ena  = 1'b0;
    endtask

    task automatic drainA(input int budget);
        int n = 0;
        a_out_rdy = 1'b1;
        while (qa.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        a_out_rdy = 1'b0;
        if (qa.size() > 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL A drain timeout: observed %0d words left expected 0", qa.size());
            qa.delete();
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        qa.delete();
    endtask

    task automatic cleanFrame(input string tag);
        applyStimulus(W0C, W0D);
        applyStimulus(W1C, W1D);
        applyStimulus(W2C, W2D);
        applyStimulus(W3C, W3D);
        checkOutput({tag, " level full"}, 72'(a_level), 72'd16);
        qa.push_back({8'h01, W1D, W0D});
        qa.push_back({8'hFE, W3D, W2D});
        drainA(10);
        checkOutput({tag, " level empty"}, 72'(a_level), 72'd0);
        checkOutput({tag, " no underrun"}, 72'(a_unf), 72'd0);
    endtask

    initial begin
        rst = 1'b1;
        a_in_ena = 0; a_in_ctrl = 0; a_in_data = 0; a_out_rdy = 0; a_clr = 0;
        b_in_ena = 0; b_in_ctrl = 0; b_in_data = 0; b_out_rdy = 0; b_clr = 0;
        tick();
        tick();
        checkOutput("reset out_ena", 72'(a_out_ena), 72'd0);
        checkOutput("reset out word", {a_out_ctrl, a_out_data}, 72'd0);
        checkOutput("reset level", 72'(a_level), 72'd0);
        checkOutput("reset flags", {70'b0, a_ovf, a_unf}, 72'd0);
        checkOutput("reset B level", 72'(b_level), 72'd0);
        rst = 1'b0;

        $display("[TB] 4->8 frame");
        cleanFrame("frame1");

        $display("[TB] 8->4 split");
        b_in_ena = 1'b1; b_in_ctrl = 8'hE1; b_in_data = 64'h0707FDD5_555555FB;
        tick();
        b_in_ena = 1'b0;
        checkOutput("B level after push", 72'(b_level), 72'd8);
        qb.push_back({36'b0, 4'h1, 32'h555555FB});
        qb.push_back({36'b0, 4'hE, 32'h0707FDD5});
        b_out_rdy = 1'b1;
        tick();
        checkOutput("B first out_ena", 72'(b_out_ena), 72'd1);
        checkOutput("B level half", 72'(b_level), 72'd4);
        tick();
        b_out_rdy = 1'b0;
        checkOutput("B level empty", 72'(b_level), 72'd0);
        tick();
        checkOutput("B idle out_ena", 72'(b_out_ena), 72'd0);
        checkOutput("B queue drained", 72'(qb.size()), 72'd0);

        $display("[TB] simultaneous push/pop and underrun");
        applyStimulus(W0C, W0D);
        applyStimulus(W1C, W1D);
        qa.push_back({8'h01, W1D, W0D});
        a_out_rdy = 1'b1;
        applyStimulus(WXC, WXD);
        a_out_rdy = 1'b0;
        checkOutput("push4 pop8 level", 72'(a_level), 72'd4);
        qa.push_back({8'hFF, 64'hFEFEFEFE_FEFEFEFE});
        a_out_rdy = 1'b1;
        tick();
        a_out_rdy = 1'b0;
        checkOutput("underrun set", 72'(a_unf), 72'd1);
        checkOutput("underrun queue", 72'(qa.size()), 72'd0);
        tick();
        checkOutput("flush partial", 72'(a_level), 72'd0);
        applyStimulus(W2C, W2D);
        tick();
        checkOutput("flush through T", 72'(a_level), 72'd2);
        a_out_rdy = 1'b1;
        tick();
        a_out_rdy = 1'b0;
        checkOutput("idle short level", 72'(a_out_ena), 72'd0);
        checkOutput("idle level kept", 72'(a_level), 72'd2);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        checkOutput("underrun cleared", 72'(a_unf), 72'd0);
        doReset();

        $display("[TB] overflow discard");
        applyStimulus(W0C, W0D);
        for (int i = 0; i < 7; i++) applyStimulus(W1C, W1D);
        checkOutput("full level", 72'(a_level), 72'd32);
        checkOutput("no overflow yet", 72'(a_ovf), 72'd0);
        a_clr = 1'b1;
        applyStimulus(W1C, W1D);
        a_clr = 1'b0;
        checkOutput("overflow set over clr", 72'(a_ovf), 72'd1);
        checkOutput("ninth dropped", 72'(a_level), 72'd32);
        qa.push_back({8'h01, W1D, W0D});
        a_out_rdy = 1'b1;
        tick();
        a_out_rdy = 1'b0;
        checkOutput("after one pop", 72'(a_level), 72'd24);
        applyStimulus(W1C, W1D);
        checkOutput("E word pushed", 72'(a_level), 72'd28);
        applyStimulus(W1C, W1D);
        checkOutput("single E word", 72'(a_level), 72'd28);
        applyStimulus(W2C, W2D);
        checkOutput("T word dropped", 72'(a_level), 72'd28);
        applyStimulus(W3C, W3D);
        checkOutput("back in pass", 72'(a_level), 72'd32);
        for (int i = 0; i < 3; i++) qa.push_back({8'h00, W1D, W1D});
        qa.push_back({8'hFF, W3D, 32'hFEFEFEFE});
        drainA(10);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        checkOutput("overflow cleared", 72'(a_ovf), 72'd0);
        doReset();

        $display("[TB] reset mid-frame");
        applyStimulus(W0C, W0D);
        for (int i = 0; i < 4; i++) applyStimulus(W1C, W1D);
        qa.push_back({8'h01, W1D, W0D});
        a_out_rdy = 1'b1;
        tick();
        a_out_rdy = 1'b0;
        checkOutput("frame level 12", 72'(a_level), 72'd12);
        checkOutput("frame out_ena", 72'(a_out_ena), 72'd1);
        rst = 1'b1;
        #1;
        checkOutput("async rst level", 72'(a_level), 72'd0);
        checkOutput("async rst out_ena", 72'(a_out_ena), 72'd0);
        checkOutput("async rst flags", {70'b0, a_ovf, a_unf}, 72'd0);
        doReset();
        cleanFrame("frame2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
